// File: rtl/player_pkg.sv
// Shared types and default geometry for the player controller and its shot pool.
package player_pkg;

  localparam int DEF_COORD_W    = 10;
  localparam int DEF_X_MIN      = 90;
  localparam int DEF_X_MAX      = 550;
  localparam int DEF_Y_PARK     = 470;
  localparam int DEF_HIT_HALF_W = 15;
  localparam int DEF_HIT_DEPTH  = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

endpackage

// File: rtl/player_ctrl_multi_shot_pool.sv
// Pool of player projectiles: lowest-free-slot allocation, upward motion,
// retirement on top-of-screen or enemy strike, and packed slot outputs.
module shot_pool
  import player_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int NUM_SHOTS = 4,
  parameter int Y_START   = 420,
  parameter int Y_PARK    = DEF_Y_PARK,
  parameter int SHOT_STEP = 2
) (
  input  logic                           dclk,
  input  logic                           clr,
  input  logic                           clear_i,
  input  logic                           step_i,
  input  logic                           fire_i,
  input  logic [COORD_W-1:0]             fire_x_i,
  input  logic [NUM_SHOTS-1:0]           shot_hit_i,
  output logic [NUM_SHOTS-1:0]           valid_o,
  output logic [NUM_SHOTS*COORD_W-1:0]   x_o,
  output logic [NUM_SHOTS*COORD_W-1:0]   y_o
);

  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(SHOT_STEP);
  localparam logic [COORD_W-1:0] START_C = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] PARK_C  = COORD_W'(Y_PARK);

  logic [NUM_SHOTS-1:0] valid_q, valid_d;
  logic [COORD_W-1:0]   x_q [NUM_SHOTS];
  logic [COORD_W-1:0]   x_d [NUM_SHOTS];
  logic [COORD_W-1:0]   y_q [NUM_SHOTS];
  logic [COORD_W-1:0]   y_d [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] alloc_oh;
  logic                 found;

  // Allocation looks only at registered occupancy, so a slot retiring this
  // cycle cannot be refilled until the next tick.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_SHOTS; k++) begin
      if (!valid_q[k] && !found) begin
        alloc_oh[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    for (int k = 0; k < NUM_SHOTS; k++) begin
      if (clear_i) begin
        valid_d[k] = 1'b0;
        x_d[k]     = '0;
        y_d[k]     = PARK_C;
      end else if (valid_q[k]) begin
        if (shot_hit_i[k] || (step_i && (y_q[k] < STEP_C))) begin
          valid_d[k] = 1'b0;
          x_d[k]     = '0;
          y_d[k]     = PARK_C;
        end else if (step_i) begin
          y_d[k] = y_q[k] - STEP_C;
        end
      end else if (fire_i && alloc_oh[k]) begin
        valid_d[k] = 1'b1;
        x_d[k]     = fire_x_i;
        y_d[k]     = START_C;
      end
    end
  end

  // NOTE: the slot arrays are small registers with architectural reset values,
  // so they are reset element by element rather than left to a RAM.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_SHOTS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= PARK_C;
      end
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    x_o     = '0;
    y_o     = '0;
    valid_o = valid_q;
    for (int k = 0; k < NUM_SHOTS; k++) begin
      x_o[k*COORD_W +: COORD_W] = x_q[k];
      y_o[k*COORD_W +: COORD_W] = y_q[k];
    end
  end

endmodule

// File: rtl/player_ctrl_multi.sv
// Player controller: position, shot pool, hazard collision, lives and game FSM.
// Define AUTOFIRE_EN to add held-button repeat fire every FIRE_PERIOD ticks.
module player_ctrl_multi
  import player_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int NUM_SHOTS  = 4,
  parameter int NUM_HAZ    = 11,
  parameter int X_MIN      = DEF_X_MIN,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int X_START    = 320,
  parameter int Y_START    = 420,
  parameter int Y_PARK     = DEF_Y_PARK,
  parameter int SHOT_STEP  = 2,
  parameter int HIT_HALF_W = DEF_HIT_HALF_W,
  parameter int HIT_DEPTH  = DEF_HIT_DEPTH,
  parameter int LIVES_INIT = 3,
`ifdef AUTOFIRE_EN
  parameter int INV_TICKS  = 64,
  parameter int FIRE_PERIOD = 16
`else
  parameter int INV_TICKS  = 64
`endif
) (
  input  logic                         dclk,
  input  logic                         clr,
  input  logic                         tick,
  input  logic                         play,
  input  logic                         left,
  input  logic                         right,
  input  logic                         shoot,
  input  logic [NUM_SHOTS-1:0]         shot_hit,
  input  logic [NUM_HAZ-1:0]           haz_valid,
  input  logic [NUM_HAZ*COORD_W-1:0]   haz_x,
  input  logic [NUM_HAZ*COORD_W-1:0]   haz_y,
  output logic [COORD_W-1:0]           player_x,
  output logic [COORD_W-1:0]           player_y,
  output logic [NUM_SHOTS-1:0]         shots_valid,
  output logic [NUM_SHOTS*COORD_W-1:0] shots_x,
  output logic [NUM_SHOTS*COORD_W-1:0] shots_y,
  output logic [1:0]                   lives,
  output logic                         invuln,
  output logic                         hit_pulse,
  output logic                         gameover,
  output logic [1:0]                   state
);

  localparam int INV_W = $clog2(INV_TICKS + 1);
  typedef logic [COORD_W:0] coord_e_t;

  localparam logic [COORD_W-1:0] X_MIN_C   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] ONE_C     = COORD_W'(1);
  localparam coord_e_t           HALF_E    = coord_e_t'(HIT_HALF_W);
  localparam coord_e_t           DEPTH_E   = coord_e_t'(HIT_DEPTH);
  localparam coord_e_t           PY_E      = coord_e_t'(Y_START);
  localparam logic [INV_W-1:0]   INV_C     = INV_W'(INV_TICKS);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [1:0]         lives_q, lives_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               shoot_q, shoot_d;

  logic     step, active, any_hit, hit_now, fire;
  coord_e_t hx, hy, px_e;

  assign step    = tick && play;
  assign active  = (state_q == ST_PLAY) || (state_q == ST_INVULN);
  assign hit_now = step && (state_q == ST_PLAY) && any_hit;
  assign px_e    = {1'b0, px_q};

  // Window tests are written as additions only, so nothing can underflow.
  always_comb begin
    any_hit = 1'b0;
    hx      = '0;
    hy      = '0;
    for (int i = 0; i < NUM_HAZ; i++) begin
      hx = {1'b0, haz_x[i*COORD_W +: COORD_W]};
      hy = {1'b0, haz_y[i*COORD_W +: COORD_W]};
      if (haz_valid[i] && (hy < PY_E) && (PY_E < hy + DEPTH_E) &&
          (hx + HALF_E > px_e) && (hx < px_e + HALF_E)) begin
        any_hit = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping play is the synchronous restart path.
  always_comb begin
    state_d = state_q;
    if (!play) begin
      state_d = ST_IDLE;
    end else if (tick) begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_PLAY;
        ST_PLAY:   if (any_hit) state_d = (lives_q == 2'd1) ? ST_OVER : ST_INVULN;
        ST_INVULN: if (inv_q <= INV_W'(1)) state_d = ST_PLAY;
        ST_OVER:   state_d = ST_OVER;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    px_d        = px_q;
    lives_d     = lives_q;
    inv_d       = inv_q;
    shoot_d     = shoot_q;
    hit_pulse_d = hit_now;
    if (!play) begin
      px_d    = X_START_C;
      lives_d = 2'(LIVES_INIT);
      inv_d   = '0;
      shoot_d = 1'b0;
    end else if (step && (state_q != ST_IDLE)) begin
      shoot_d = shoot;
      if (active) begin
        if (left) begin
          if (px_q > X_MIN_C) px_d = px_q - ONE_C;
        end else if (right) begin
          if (px_q < X_MAX_C) px_d = px_q + ONE_C;
        end
      end
      if (hit_now) begin
        lives_d = lives_q - 2'd1;
        inv_d   = (lives_q == 2'd1) ? '0 : INV_C;
      end else if ((state_q == ST_INVULN) && (inv_q != '0)) begin
        inv_d = inv_q - INV_W'(1);
      end
    end
  end

`ifdef AUTOFIRE_EN
  localparam int AF_W = $clog2(FIRE_PERIOD + 1);
  logic [AF_W-1:0] af_q, af_d;

  // Repeat counter runs only while the button stays held; release rearms it.
  always_comb begin
    af_d = af_q;
    fire = 1'b0;
    if (!play) begin
      af_d = '0;
    end else if (step && active) begin
      if (!shoot) begin
        af_d = '0;
      end else if (!shoot_q || (af_q == '0)) begin
        fire = 1'b1;
        af_d = AF_W'(FIRE_PERIOD - 1);
      end else begin
        af_d = af_q - AF_W'(1);
      end
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) af_q <= '0;
    else     af_q <= af_d;
  end
`else
  assign fire = step && active && shoot && !shoot_q;
`endif

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      px_q        <= X_START_C;
      lives_q     <= 2'(LIVES_INIT);
      inv_q       <= '0;
      hit_pulse_q <= 1'b0;
      shoot_q     <= 1'b0;
    end else begin
      px_q        <= px_d;
      lives_q     <= lives_d;
      inv_q       <= inv_d;
      hit_pulse_q <= hit_pulse_d;
      shoot_q     <= shoot_d;
    end
  end

  shot_pool #(
    .COORD_W   (COORD_W),
    .NUM_SHOTS (NUM_SHOTS),
    .Y_START   (Y_START),
    .Y_PARK    (Y_PARK),
    .SHOT_STEP (SHOT_STEP)
  ) u_shot_pool (
    .dclk       (dclk),
    .clr        (clr),
    .clear_i    (!play),
    .step_i     (step && (state_q != ST_IDLE)),
    .fire_i     (fire),
    .fire_x_i   (px_q),
    .shot_hit_i (shot_hit),
    .valid_o    (shots_valid),
    .x_o        (shots_x),
    .y_o        (shots_y)
  );

  // Output logic
  always_comb begin
    state     = state_q;
    player_x  = px_q;
    player_y  = COORD_W'(Y_START);
    lives     = lives_q;
    hit_pulse = hit_pulse_q;
    invuln    = (state_q == ST_INVULN);
    gameover  = (state_q == ST_OVER);
  end

endmodule
